// File: rtl/param_register_file.sv
// Parametrised register file: two registered read ports, one write port, immediate
// substitution on port 2, and a sequential bulk-clear engine. Define REGFILE_BYPASS_EN for write-to-read forwarding.
module param_register_file #(
  parameter int DATA_WIDTH = 8,
  parameter int REG_COUNT  = 8,
  parameter int ADDR_WIDTH = $clog2(REG_COUNT)
) (
  input  logic                  clock,
  input  logic                  resetN,
  input  logic                  regWrite,
  input  logic [ADDR_WIDTH-1:0] writeRegister,
  input  logic [DATA_WIDTH-1:0] writeData,
  input  logic [ADDR_WIDTH-1:0] readRegister1,
  input  logic [ADDR_WIDTH-1:0] readRegister2,
  input  logic                  immediate,
  input  logic [DATA_WIDTH-1:0] ltValue,
  input  logic                  clearStart,
  output logic                  busy,
  output logic [DATA_WIDTH-1:0] readData1,
  output logic [DATA_WIDTH-1:0] readData2
);

  localparam logic [ADDR_WIDTH:0]   COUNT_EXT  = (ADDR_WIDTH + 1)'(REG_COUNT);
  localparam logic [ADDR_WIDTH-1:0] LAST_INDEX = ADDR_WIDTH'(REG_COUNT - 1);

  // Handshake: no ready/valid pair here; upstream must hold writes while busy=1,
  // and any write presented during the sweep is dropped without notice.
  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } stateT;

  stateT                  state;
  logic [ADDR_WIDTH-1:0]  clearPointer;
  logic [DATA_WIDTH-1:0]  registers [REG_COUNT];
  logic                   writeAccept;
  logic [DATA_WIDTH-1:0]  readNext1;
  logic [DATA_WIDTH-1:0]  readNext2;

  function automatic logic inRange(input logic [ADDR_WIDTH-1:0] addr);
    return {1'b0, addr} < COUNT_EXT;
  endfunction

  assign writeAccept = regWrite && (state == IDLE) && inRange(writeRegister);
  assign busy        = (state == CLEAR);

  always_comb begin
    readNext1 = '0;
    readNext2 = '0;
    if (inRange(readRegister1)) readNext1 = registers[readRegister1];
    if (inRange(readRegister2)) readNext2 = registers[readRegister2];
`ifdef REGFILE_BYPASS_EN
    // Forward the word landing this edge; an entry being swept reads as already cleared.
    if (writeAccept && (writeRegister == readRegister1)) readNext1 = writeData;
    if (writeAccept && (writeRegister == readRegister2)) readNext2 = writeData;
    if ((state == CLEAR) && (clearPointer == readRegister1)) readNext1 = '0;
    if ((state == CLEAR) && (clearPointer == readRegister2)) readNext2 = '0;
`endif
    if (immediate) readNext2 = ltValue;
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state        <= IDLE;
      clearPointer <= '0;
      readData1    <= '0;
      readData2    <= '0;
      for (int i = 0; i < REG_COUNT; i++) registers[i] <= '0;
    end else begin
      readData1 <= readNext1;
      readData2 <= readNext2;
      case (state)
        IDLE: begin
          if (writeAccept) registers[writeRegister] <= writeData;
          if (clearStart) begin
            state        <= CLEAR;
            clearPointer <= '0;
          end
        end
        CLEAR: begin
          registers[clearPointer] <= '0;
          // Stop on the last real index so non-power-of-two sizes never overrun.
          if (clearPointer == LAST_INDEX) begin
            state        <= IDLE;
            clearPointer <= '0;
          end else begin
            clearPointer <= clearPointer + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
